// File: rtl/alu_pkg.sv
// Shared definitions for the calculator ALU command path: operand width,
// one-hot opcode constants, sequencer state type and the opcode legality check.
package alu_pkg;

    localparam int OPND_W = 4;

    typedef logic [OPND_W-1:0] opnd_t;

    localparam opnd_t OP_CLR = 4'b0000;
    localparam opnd_t OP_ADD = 4'b0001;
    localparam opnd_t OP_SUB = 4'b0010;
    localparam opnd_t OP_MUL = 4'b0100;
    localparam opnd_t OP_DIV = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Clear (all zeros) or exactly one opcode bit set.
    function automatic logic op_is_legal(input opnd_t op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_CLR, OP_ADD, OP_SUB, OP_MUL, OP_DIV: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_cmd_seq_if.sv
// Bundle of the request, result and ALU-side signals of the command sequencer.
// master = the sequencer itself, slave = front end plus ALU around it.
interface alu_cmd_seq_if;

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [alu_pkg::OPND_W-1:0]  cmd_a;
    logic [alu_pkg::OPND_W-1:0]  cmd_b;
    logic [alu_pkg::OPND_W-1:0]  cmd_op;

    logic                        res_valid;
    logic                        res_ready;
    logic [alu_pkg::OPND_W-1:0]  res_data;
    logic                        res_err;

    logic                        alu_sel;
    logic                        wr_enable;
    logic [alu_pkg::OPND_W-1:0]  first_nr;
    logic [alu_pkg::OPND_W-1:0]  second_nr;
    logic [alu_pkg::OPND_W-1:0]  operation;
    logic [alu_pkg::OPND_W-1:0]  result_uncoded;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, res_ready, result_uncoded,
        output cmd_ready, res_valid, res_data, res_err,
               alu_sel, wr_enable, first_nr, second_nr, operation
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, res_ready, result_uncoded,
        input  cmd_ready, res_valid, res_data, res_err,
               alu_sel, wr_enable, first_nr, second_nr, operation
    );

endinterface

// File: rtl/alu_cmd_seq.sv
// Command sequencer: accepts one ALU request, strobes the ALU, waits RESULT_LAT
// cycles and holds the result. Define ALU_CMD_SEQ_DIV0_CHK_EN to reject divide-by-zero.
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int RESULT_LAT = 3
) (
    input  logic          clk,
    input  logic          rst,
    alu_cmd_seq_if.master bus
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESULT_LAT - 1);

    seq_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cmd_ready_q;
    logic              res_valid_q;
    logic              res_err_q;
    opnd_t             res_data_q;
    logic              alu_sel_q;
    logic              wr_enable_q;
    opnd_t             first_nr_q;
    opnd_t             second_nr_q;
    opnd_t             operation_q;

    logic cmd_fire;
    logic div0_reject;
    logic cmd_legal;

    // cmd_ready_q is only ever set while in IDLE, so it also qualifies the state.
    assign cmd_fire = bus.cmd_valid && cmd_ready_q;

`ifdef ALU_CMD_SEQ_DIV0_CHK_EN
    assign div0_reject = (bus.cmd_op == OP_DIV) && (bus.cmd_b == '0);
`else
    assign div0_reject = 1'b0;
`endif

    assign cmd_legal = op_is_legal(bus.cmd_op) && !div0_reject;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_data_q  <= '0;
            alu_sel_q   <= 1'b0;
            wr_enable_q <= 1'b0;
            first_nr_q  <= '0;
            second_nr_q <= '0;
            operation_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_fire) begin
                        cmd_ready_q <= 1'b0;
                        if (cmd_legal) begin
                            first_nr_q  <= bus.cmd_a;
                            second_nr_q <= bus.cmd_b;
                            operation_q <= bus.cmd_op;
                            alu_sel_q   <= 1'b1;
                            wr_enable_q <= 1'b1;
                            state_q     <= ST_WRITE;
                        end else begin
                            // Rejected: result is prepared now, res_valid follows from DONE.
                            res_err_q  <= 1'b1;
                            res_data_q <= '0;
                            state_q    <= ST_DONE;
                        end
                    end
                end

                ST_WRITE: begin
                    alu_sel_q   <= 1'b0;
                    wr_enable_q <= 1'b0;
                    cnt_q       <= CNT_LOAD;
                    state_q     <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        res_data_q  <= bus.result_uncoded;
                        res_err_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                ST_DONE: begin
                    if (!res_valid_q) begin
                        res_valid_q <= 1'b1;
                    end else if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_err   = res_err_q;
    assign bus.res_data  = res_data_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.wr_enable = wr_enable_q;
    assign bus.first_nr  = first_nr_q;
    assign bus.second_nr = second_nr_q;
    assign bus.operation = operation_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq: three instances (RESULT_LAT 3, 1, 15)
// share one stimulus stream, each fed by its own behavioural ALU model.
module tb_alu_cmd_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [3:0] cmd_a, cmd_b, cmd_op;
    logic       res_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] op);
        logic [3:0] r;
        case (op)
            4'b0000: r = 4'd0;
            4'b0001: r = 4'(a + b);
            4'b0010: r = 4'(a - b);
            4'b0100: r = 4'(a * b);
            4'b1000: r = (b == 4'd0) ? 4'hF : 4'(a / b);
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    function automatic bit expect_reject(input logic [3:0] op, input logic [3:0] b);
        bit rej;
        rej = !(op inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000});
`ifdef ALU_CMD_SEQ_DIV0_CHK_EN
        if (op == 4'b1000 && b == 4'd0) rej = 1'b1;
`endif
        return rej;
    endfunction

    alu_cmd_seq_if if3 ();
    alu_cmd_seq_if if1 ();
    alu_cmd_seq_if if15 ();

    assign if3.cmd_valid  = cmd_valid;  assign if1.cmd_valid  = cmd_valid;  assign if15.cmd_valid  = cmd_valid;
    assign if3.cmd_a      = cmd_a;      assign if1.cmd_a      = cmd_a;      assign if15.cmd_a      = cmd_a;
    assign if3.cmd_b      = cmd_b;      assign if1.cmd_b      = cmd_b;      assign if15.cmd_b      = cmd_b;
    assign if3.cmd_op     = cmd_op;     assign if1.cmd_op     = cmd_op;     assign if15.cmd_op     = cmd_op;
    assign if3.res_ready  = res_ready;  assign if1.res_ready  = res_ready;  assign if15.res_ready  = res_ready;
    assign if3.result_uncoded  = alu_model(if3.first_nr, if3.second_nr, if3.operation);
    assign if1.result_uncoded  = alu_model(if1.first_nr, if1.second_nr, if1.operation);
    assign if15.result_uncoded = alu_model(if15.first_nr, if15.second_nr, if15.operation);

    alu_cmd_seq #(.RESULT_LAT(3))  dut3  (.clk(clk), .rst(rst), .bus(if3));
    alu_cmd_seq #(.RESULT_LAT(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
    alu_cmd_seq #(.RESULT_LAT(15)) dut15 (.clk(clk), .rst(rst), .bus(if15));

    typedef struct {
        int         lat;
        int         strobes;
        logic [3:0] sa, sb, sop;
        logic       ssel;
        logic [3:0] data;
        logic       err;
        logic       post_valid;
        logic       post_ready;
    } obs_t;

    // Issues one request to the RESULT_LAT=3 instance and records what it did;
    // lat is counted in edges after the accepting edge, -1 if no result appeared.
    task automatic run_cmd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                           input bit handshake, output obs_t o);
        int n;
        o.lat = -1; o.strobes = 0; o.sa = 0; o.sb = 0; o.sop = 0; o.ssel = 0;
        o.data = 0; o.err = 0; o.post_valid = 0; o.post_ready = 0;
        n = 0;
        while (if3.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (if3.wr_enable === 1'b1) begin
                o.strobes++;
                o.sa = if3.first_nr; o.sb = if3.second_nr; o.sop = if3.operation;
                o.ssel = if3.alu_sel;
            end
            if (if3.res_valid === 1'b1) begin
                o.lat = k; o.data = if3.res_data; o.err = if3.res_err;
                break;
            end
            @(negedge clk);
        end
        if (handshake) begin
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            o.post_valid = if3.res_valid;
            o.post_ready = if3.cmd_ready;
        end
        $display("txn a=%0d b=%0d op=%b -> lat=%0d strobes=%0d data=%0d err=%0b",
                 a, b, op, o.lat, o.strobes, o.data, o.err);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (if3.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", if3.cmd_ready); end
        checks++; if (if3.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", if3.res_valid); end
        checks++; if (if3.res_err !== 1'b0) begin errors++; $display("FAIL reset_res_err: got %b want 0", if3.res_err); end
        checks++; if (if3.res_data !== 4'd0) begin errors++; $display("FAIL reset_res_data: got %0d want 0", if3.res_data); end
        checks++; if ({if3.alu_sel, if3.wr_enable} !== 2'b00) begin errors++; $display("FAIL reset_strobe: got %b want 00", {if3.alu_sel, if3.wr_enable}); end
        checks++; if ({if3.first_nr, if3.second_nr, if3.operation} !== 12'd0) begin errors++; $display("FAIL reset_alu_bus: got %h want 000", {if3.first_nr, if3.second_nr, if3.operation}); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (if3.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", if3.cmd_ready); end
    endtask

    task automatic test_add();
        obs_t o;
        run_cmd(4'd3, 4'd4, OP_ADD, 1'b1, o);
        checks++; if (o.lat !== 4) begin errors++; $display("FAIL add_lat: got %0d want 4", o.lat); end
        checks++; if (o.strobes !== 1) begin errors++; $display("FAIL add_strobes: got %0d want 1", o.strobes); end
        checks++; if ({o.sa, o.sb, o.sop} !== {4'd3, 4'd4, 4'b0001}) begin errors++; $display("FAIL add_alu_bus: got %h want 341", {o.sa, o.sb, o.sop}); end
        checks++; if (o.ssel !== 1'b1) begin errors++; $display("FAIL add_alu_sel: got %b want 1", o.ssel); end
        checks++; if (o.data !== 4'd7) begin errors++; $display("FAIL add_data: got %0d want 7", o.data); end
        checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL add_err: got %b want 0", o.err); end
        checks++; if ({o.post_valid, o.post_ready} !== 2'b01) begin errors++; $display("FAIL add_after_hs: got valid/ready %b want 01", {o.post_valid, o.post_ready}); end
        checks++; if ({if3.first_nr, if3.second_nr, if3.operation} !== {4'd3, 4'd4, 4'b0001}) begin errors++; $display("FAIL add_alu_bus_hold: got %h want 341", {if3.first_nr, if3.second_nr, if3.operation}); end
    endtask

    task automatic test_illegal();
        obs_t o;
        run_cmd(4'd5, 4'd2, 4'b0011, 1'b1, o);
        checks++; if (o.lat !== 1) begin errors++; $display("FAIL illegal_lat: got %0d want 1", o.lat); end
        checks++; if (o.strobes !== 0) begin errors++; $display("FAIL illegal_strobes: got %0d want 0", o.strobes); end
        checks++; if (o.err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b want 1", o.err); end
        checks++; if (o.data !== 4'd0) begin errors++; $display("FAIL illegal_data: got %0d want 0", o.data); end
        checks++; if ({if3.first_nr, if3.second_nr, if3.operation} !== {4'd3, 4'd4, 4'b0001}) begin errors++; $display("FAIL illegal_alu_bus_kept: got %h want 341", {if3.first_nr, if3.second_nr, if3.operation}); end
    endtask

    task automatic test_backpressure();
        obs_t o;
        int bad;
        run_cmd(4'd5, 4'd6, OP_ADD, 1'b0, o);
        checks++; if (o.data !== 4'd11) begin errors++; $display("FAIL bp_data: got %0d want 11", o.data); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cmd_a = 4'd1; cmd_b = 4'd1; cmd_op = OP_SUB; cmd_valid = 1'b1;
            @(negedge clk);
            if (if3.res_valid !== 1'b1 || if3.res_data !== 4'd11 || if3.res_err !== 1'b0 ||
                if3.cmd_ready !== 1'b0 || if3.wr_enable !== 1'b0) bad++;
        end
        cmd_valid = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++; if ({if3.res_valid, if3.cmd_ready} !== 2'b01) begin errors++; $display("FAIL bp_release: got valid/ready %b want 01", {if3.res_valid, if3.cmd_ready}); end
    endtask

    task automatic test_reset_mid();
        int seen;
        cmd_a = 4'd2; cmd_b = 4'd2; cmd_op = OP_MUL; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (if3.res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", if3.res_valid); end
        @(negedge clk);
        checks++; if (if3.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", if3.cmd_ready); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (if3.res_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_result: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_div0();
        obs_t o;
        bit   rej;
        rej = expect_reject(OP_DIV, 4'd0);
        run_cmd(4'd9, 4'd0, OP_DIV, 1'b1, o);
        checks++; if (o.err !== rej) begin errors++; $display("FAIL div0_err: got %b want %b", o.err, rej); end
        checks++; if (o.strobes !== (rej ? 0 : 1)) begin errors++; $display("FAIL div0_strobes: got %0d want %0d", o.strobes, rej ? 0 : 1); end
        checks++; if (o.lat !== (rej ? 1 : 4)) begin errors++; $display("FAIL div0_lat: got %0d want %0d", o.lat, rej ? 1 : 4); end
        checks++; if (o.data !== (rej ? 4'd0 : alu_model(4'd9, 4'd0, OP_DIV))) begin errors++; $display("FAIL div0_data: got %0d", o.data); end
    endtask

    task automatic test_random();
        obs_t       o;
        logic [3:0] a, b, op, exp_data;
        bit         rej;
        int         sel;
        logic [3:0] legal_ops [5];
        legal_ops[0] = OP_CLR; legal_ops[1] = OP_ADD; legal_ops[2] = OP_SUB;
        legal_ops[3] = OP_MUL; legal_ops[4] = OP_DIV;
        for (int t = 0; t < 25; t++) begin
            a   = 4'($urandom_range(0, 15));
            b   = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            sel = $urandom_range(0, 6);
            op  = (sel < 5) ? legal_ops[sel] : 4'($urandom_range(0, 15));
            rej = expect_reject(op, b);
            exp_data = rej ? 4'd0 : alu_model(a, b, op);
            run_cmd(a, b, op, 1'b1, o);
            checks++; if (o.lat !== (rej ? 1 : 4)) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", t, o.lat, rej ? 1 : 4); end
            checks++; if (o.data !== exp_data || o.err !== rej) begin errors++; $display("FAIL rnd_result[%0d]: got data=%0d err=%b want data=%0d err=%b", t, o.data, o.err, exp_data, rej); end
            checks++; if (o.strobes !== (rej ? 0 : 1)) begin errors++; $display("FAIL rnd_strobes[%0d]: got %0d want %0d", t, o.strobes, rej ? 0 : 1); end
            if (!rej) begin
                checks++; if ({o.sa, o.sb, o.sop} !== {a, b, op}) begin errors++; $display("FAIL rnd_alu_bus[%0d]: got %h want %h", t, {o.sa, o.sb, o.sop}, {a, b, op}); end
            end
            checks++; if ({o.post_valid, o.post_ready} !== 2'b01) begin errors++; $display("FAIL rnd_after_hs[%0d]: got %b want 01", t, {o.post_valid, o.post_ready}); end
        end
    endtask

    task automatic test_latency();
        int         lat1, lat15, lat3;
        logic [3:0] d1, d15, exp;
        logic [3:0] ops [2];
        ops[0] = OP_CLR; ops[1] = OP_SUB;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            lat1 = -1; lat15 = -1; lat3 = -1; d1 = 4'hx; d15 = 4'hx;
            exp = alu_model(4'd9, 4'd5, ops[r]);
            cmd_a = 4'd9; cmd_b = 4'd5; cmd_op = ops[r]; cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            for (int k = 0; k <= 24; k++) begin
                if (lat1 < 0 && if1.res_valid === 1'b1) begin lat1 = k; d1 = if1.res_data; end
                if (lat15 < 0 && if15.res_valid === 1'b1) begin lat15 = k; d15 = if15.res_data; end
                if (lat3 < 0 && if3.res_valid === 1'b1) lat3 = k;
                @(negedge clk);
            end
            $display("txn lat op=%b -> lat1=%0d lat15=%0d lat3=%0d d1=%0d d15=%0d", ops[r], lat1, lat15, lat3, d1, d15);
            checks++; if (lat1 !== 2) begin errors++; $display("FAIL lat1_cycles: got %0d want 2", lat1); end
            checks++; if (lat15 !== 16) begin errors++; $display("FAIL lat15_cycles: got %0d want 16", lat15); end
            checks++; if (lat3 !== 4) begin errors++; $display("FAIL lat3_cycles: got %0d want 4", lat3); end
            checks++; if (d1 !== exp || d15 !== exp) begin errors++; $display("FAIL lat_data: got %0d/%0d want %0d", d1, d15, exp); end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = 4'd0; cmd_b = 4'd0; cmd_op = 4'd0; res_ready = 1'b0;
        test_reset();
        test_add();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_div0();
        test_random();
        test_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_seq.md
# alu_cmd_seq

Command sequencer that acts as the initiator for the calculator ALU write/result interface. It accepts one operation request (two 4-bit operands and a one-hot opcode) over a valid/ready handshake and validates the opcode. It then issues a single-cycle write strobe to the ALU, waits a fixed result latency, captures the ALU result and holds it on a valid/ready result port. It sits between the keypad/control front end and the ALU.

## Interface
- RESULT_LAT, 3: cycles from the ALU write-strobe edge to the edge at which `result_uncoded` is sampled; legal range 1..15.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- cmd_valid  input  1  request present.
- cmd_ready  output  1  sequencer can accept a request; high only in IDLE.
- cmd_a  input  4  first operand.
- cmd_b  input  4  second operand.
- cmd_op  input  4  opcode: 0000 clear, 0001 add, 0010 sub, 0100 mult, 1000 div.
- res_valid  output  1  result held and valid.
- res_ready  input  1  consumer takes the result.
- res_data  output  4  captured result.
- res_err  output  1  request rejected; `res_data` is 0.
- alu_sel  output  1  ALU select, pulsed together with `wr_enable`.
- wr_enable  output  1  ALU write strobe.
- first_nr  output  4  operand A to the ALU.
- second_nr  output  4  operand B to the ALU.
- operation  output  4  opcode to the ALU.
- result_uncoded  input  4  ALU result.

## Operation
- States: IDLE, WRITE, WAIT, DONE.
- IDLE:
  - `cmd_ready` is 1.
  - On `cmd_valid`, latch `cmd_a`, `cmd_b` and `cmd_op`.
  - Legal opcode (0000 or one-hot) -> WRITE.
  - Any other opcode -> DONE with `res_err`=1, `res_data`=0; no ALU access.
- WRITE (exactly 1 cycle):
  - `alu_sel`=`wr_enable`=1.
  - `first_nr`, `second_nr` and `operation` are driven from the latched values.
  - Load the wait counter with RESULT_LAT-1, then -> WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture `result_uncoded` into `res_data` with `res_err`=0, then -> DONE.
- DONE:
  - `res_valid`=1; `res_data` and `res_err` stay stable.
  - `res_valid & res_ready` -> IDLE.
- Outside WRITE, `alu_sel`=`wr_enable`=0. `first_nr`, `second_nr` and `operation` keep their last driven values.
- Arithmetic: no width changes. Results are 4 bits as returned by the ALU, with wrap-around as the ALU defines it; the sequencer never modifies them.

## Timing
- Reset values: `cmd_ready`=0 during the reset cycle, then 1; `res_valid`=0, `res_err`=0, `res_data`=0; `alu_sel`=`wr_enable`=0; `first_nr`=`second_nr`=`operation`=0; state IDLE.
- Acceptance at edge E gives:
  - strobe high during cycle E..E+1;
  - `result_uncoded` sampled at edge E+1+RESULT_LAT;
  - `res_valid` high from edge E+1+RESULT_LAT.
  - With the default RESULT_LAT, this is 4 cycles after acceptance.
- Error path: `res_valid` goes high 1 cycle after acceptance.
- Throughput: no overlap. The earliest next acceptance is the cycle after the result handshake, because `cmd_ready` returns 1 the cycle after leaving DONE.
- `res_ready` while `res_valid`=0 is ignored.
- `cmd_valid` outside IDLE is ignored; the request must be held by the source.
- Reset mid-operation: an in-flight command and any held result are discarded and the next state is IDLE. An ALU write already issued is not cancelled, but its result is never reported.

## Configuration
- `ALU_CMD_SEQ_DIV0_CHK_EN` defined: `cmd_op`=1000 with `cmd_b`=0 is rejected in IDLE, taking the error path (`res_err`=1, `res_data`=0, no strobe).
- `ALU_CMD_SEQ_DIV0_CHK_EN` undefined: that request is forwarded to the ALU like any legal command, and the ALU result is reported with `res_err`=0.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants OP_CLR, OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - the sequencer state typedef (IDLE/WRITE/WAIT/DONE);
  - the operand width constant (4).
- No sub-module: the latency counter and the opcode check are inline.

## Test plan
- Add: `cmd_a`=3, `cmd_b`=4, `cmd_op`=0001; ALU model returns 7 -> one strobe cycle with `first_nr`=3, `second_nr`=4, `operation`=0001; `res_valid` 4 cycles after acceptance with `res_data`=7, `res_err`=0.
- Illegal opcode 0011 -> no strobe; `res_valid` next cycle with `res_err`=1, `res_data`=0.
- Back-pressure: hold `res_ready`=0 for 10 cycles -> `res_valid`, `res_data` and `res_err` stay stable and `cmd_ready`=0 throughout; releasing `res_ready` gives `cmd_ready`=1 the following cycle.
- Reset asserted during WAIT -> next cycle `res_valid`=0, `cmd_ready`=1, no result reported.
- `cmd_op`=1000, `cmd_b`=0:
  - macro defined -> `res_err`=1 and no strobe;
  - macro undefined -> strobe issued and `res_err`=0.
- RESULT_LAT=1 and RESULT_LAT=15 with `cmd_op`=0000 -> `res_valid` exactly 2 and 16 cycles after acceptance, with `res_data` equal to the ALU model output.
